// File: rtl/single_cycle_cpu_core.sv
// single_cycle_cpu_core: 8-bit single-cycle CPU with 4 GPRs, 8-bit PC and {V,C,N,Z} flags.
// Instructions fetch on port A and data moves on port B; both reads return in the same cycle.
module single_cycle_cpu_core (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] CCR_out,
    output logic       mem_read,
    output logic       mem_write,
    output logic [7:0] mem_addr_a,
    input  logic [7:0] Instr_in,
    output logic       mem_write_enable,
    output logic [7:0] mem_addr_b,
    output logic [7:0] mem_write_data_b,
    input  logic [7:0] mem_data_out_b
);
    logic [7:0] pc_q, pc_d;
    logic [7:0] r_q [4];
    logic [3:0] ccr_q, ccr_d;
    logic       halt_q, halt_d;
    logic [3:0] op;
    logic [1:0] ra, rb, wr_idx;
    logic [7:0] a, b, res, wr_val;
    logic [8:0] t9;
    logic       wr_en;

    assign op               = Instr_in[7:4];
    assign ra               = Instr_in[3:2];
    assign rb               = Instr_in[1:0];
    assign a                = r_q[ra];
    assign b                = r_q[rb];
    assign CCR_out          = ccr_q;
    assign mem_addr_a       = pc_q;
    assign mem_addr_b       = b;
    assign mem_write_data_b = a;
    assign mem_read         = !rst && !halt_q && op == 4'h8;
    assign mem_write        = !rst && !halt_q && op == 4'h9;
    assign mem_write_enable = mem_write;

    always_comb begin
        pc_d   = halt_q ? pc_q : pc_q + 8'd1;
        ccr_d  = ccr_q;
        halt_d = halt_q;
        wr_en  = 1'b0;
        wr_idx = ra;
        wr_val = a;
        t9     = '0;
        res    = '0;
        if (!halt_q) begin
            case (op)
                4'h1: begin wr_en = 1'b1; wr_val = b; end
                4'h2: begin
                    t9 = {1'b0, a} + {1'b0, b}; res = t9[7:0]; wr_en = 1'b1; wr_val = res;
                    ccr_d = {a[7] == b[7] && res[7] != a[7], t9[8], res[7], res == 8'h00};
                end
                4'h3: begin
                    t9 = {1'b0, a} - {1'b0, b}; res = t9[7:0]; wr_en = 1'b1; wr_val = res;
                    ccr_d = {a[7] != b[7] && res[7] != a[7], t9[8], res[7], res == 8'h00};
                end
                4'h4, 4'h5: begin
                    res = op[0] ? a | b : a & b; wr_en = 1'b1; wr_val = res;
                    ccr_d[1:0] = {res[7], res == 8'h00};
                end
                // Unary ops act in place on R[rb]; NOT leaves C and V alone
                4'h6: begin
                    t9 = ra == 2'd0 ? {1'b0, ~b} : ra == 2'd1 ? 9'd0 - {1'b0, b} :
                         ra == 2'd2 ? {1'b0, b} + 9'd1 : {1'b0, b} - 9'd1;
                    res = t9[7:0]; wr_en = 1'b1; wr_idx = rb; wr_val = res;
                    ccr_d = {ra == 2'd0 ? ccr_q[3] : ra == 2'd2 ? b == 8'h7F : b == 8'h80,
                             ra == 2'd0 ? ccr_q[2] : t9[8], res[7], res == 8'h00};
                end
                4'h7: begin
                    wr_en = !ra[1]; wr_idx = rb;
                    wr_val = ra[0] ? {ccr_q[2], b[7:1]} : {b[6:0], ccr_q[2]};
                    ccr_d[2] = ra[1] ? !ra[0] : ra[0] ? b[0] : b[7];
                end
                4'h8: begin wr_en = 1'b1; wr_val = mem_data_out_b; end
                4'hA: pc_d = ccr_q[ra] ? b : pc_q + 8'd1;
                4'hB: pc_d = b;
                4'hC: begin wr_en = 1'b1; wr_idx = 2'd0; wr_val = {r_q[0][7:4], Instr_in[3:0]}; end
                4'hD: begin wr_en = 1'b1; wr_idx = 2'd0; wr_val = {Instr_in[3:0], r_q[0][3:0]}; end
                4'hE: begin pc_d = pc_q; halt_d = 1'b1; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= '0;
            ccr_q  <= '0;
            halt_q <= 1'b0;
            for (int i = 0; i < 4; i++) r_q[i] <= '0;
        end else begin
            pc_q   <= pc_d;
            ccr_q  <= ccr_d;
            halt_q <= halt_d;
            if (wr_en) r_q[wr_idx] <= wr_val;
        end
    end
endmodule

// File: tb/tb_single_cycle_cpu_core.sv
// tb_single_cycle_cpu_core: drives instruction bytes directly, models the data memory, scoreboards results.
module tb_single_cycle_cpu_core;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] CCR_out;
    logic       mem_read, mem_write, mem_write_enable;
    logic [7:0] mem_addr_a, Instr_in, mem_addr_b, mem_write_data_b, mem_data_out_b;
    logic [7:0] dmem [256];
    int         n_vec = 0;
    int         n_bad = 0;
    string      tag_q [$];
    logic [7:0] exp_q [$];

    single_cycle_cpu_core dut (
        .clk(clk), .rst(rst), .CCR_out(CCR_out), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr_a(mem_addr_a), .Instr_in(Instr_in), .mem_write_enable(mem_write_enable),
        .mem_addr_b(mem_addr_b), .mem_write_data_b(mem_write_data_b), .mem_data_out_b(mem_data_out_b)
    );

    always #5 clk = ~clk;
    assign mem_data_out_b = dmem[mem_addr_b];
    always @(posedge clk) if (mem_write_enable) dmem[mem_addr_b] <= mem_write_data_b;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [7:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic observe(input logic [7:0] act);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard: got %h want <empty queue>", act);
        end else check(tag_q.pop_front(), act, exp_q.pop_front());
    endtask

    task automatic exec(input logic [7:0] i);
        Instr_in = i;
        @(posedge clk);
        #1;
    endtask

    task automatic ck_reg(input string tag, input logic [1:0] r, input logic [7:0] v);
        push_exp(tag, v);
        Instr_in = {4'h0, r, 2'b00};
        #1;
        observe(mem_write_data_b);
    endtask

    task automatic ck_pc(input string tag, input logic [7:0] v);
        push_exp(tag, v);
        observe(mem_addr_a);
    endtask

    task automatic ck_ccr(input string tag, input logic [3:0] v);
        push_exp(tag, 8'(v));
        observe(8'(CCR_out));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
        Instr_in = 8'h90;
        #1;
        push_exp("rst_we", 8'h00); observe(8'(mem_write_enable));
        push_exp("rst_wr", 8'h00); observe(8'(mem_write));
        Instr_in = 8'h80;
        #1;
        push_exp("rst_rd", 8'h00); observe(8'(mem_read));
        @(posedge clk);
        #1;
        rst = 1'b0;
        ck_pc("rst_pc", 8'h00);
        ck_ccr("rst_ccr", 4'h0);
        for (int r = 0; r < 4; r++) ck_reg("rst_r", 2'(r), 8'h00);

        exec(8'hC5); exec(8'hD3); exec(8'h1C); exec(8'h23);
        ck_reg("add_r0", 2'd0, 8'h6A);
        ck_reg("mov_r3", 2'd3, 8'h35);
        ck_ccr("add_ccr", 4'h0);
        ck_pc("pc_inc", 8'h04);

        exec(8'hC1); exec(8'hD0); exec(8'h14); exec(8'hCF); exec(8'hDF); exec(8'h21);
        ck_reg("addc_r0", 2'd0, 8'h00);
        ck_ccr("addc_ccr", 4'h5);
        exec(8'h70);
        ck_reg("rlc_r0", 2'd0, 8'h01);
        ck_ccr("rlc_ccr", 4'h1);

        exec(8'hCF); exec(8'hD7); exec(8'h21);
        ck_reg("addv_r0", 2'd0, 8'h80);
        ck_ccr("addv_ccr", 4'hA);
        exec(8'h34);
        ck_reg("sub_r1", 2'd1, 8'h81);
        ck_ccr("sub_ccr", 4'hE);

        exec(8'hC0); exec(8'hD4); exec(8'h18); exec(8'hCA); exec(8'hD5); exec(8'h14);
        Instr_in = 8'h96;
        #1;
        push_exp("st_we", 8'h01);   observe(8'(mem_write_enable));
        push_exp("st_addr", 8'h40); observe(mem_addr_b);
        push_exp("st_data", 8'h5A); observe(mem_write_data_b);
        @(posedge clk);
        #1;
        Instr_in = 8'h8E;
        #1;
        push_exp("ld_rd", 8'h01); observe(8'(mem_read));
        @(posedge clk);
        #1;
        ck_reg("ld_r3", 2'd3, 8'h5A);

        exec(8'hC0); exec(8'hD2); exec(8'h18); exec(8'h30);
        ck_ccr("subz_ccr", 4'h1);
        exec(8'hA2);
        ck_pc("jz_taken", 8'h20);
        exec(8'h68);
        exec(8'hA2);
        ck_pc("jz_not", 8'h22);
        exec(8'hE0);
        ck_pc("hlt_pc", 8'h22);
        Instr_in = 8'h96;
        #1;
        push_exp("hlt_we", 8'h00); observe(8'(mem_write_enable));
        exec(8'h96); exec(8'hB2); exec(8'hC7);
        ck_pc("hlt_hold", 8'h22);
        ck_reg("hlt_r0", 2'd0, 8'h01);

        rst = 1'b1;
        exec(8'h00);
        rst = 1'b0;
        ck_pc("rst2_pc", 8'h00);
        ck_reg("rst2_r0", 2'd0, 8'h00);
        ck_ccr("rst2_ccr", 4'h0);
        exec(8'hC9);
        ck_reg("post_r0", 2'd0, 8'h09);
        ck_pc("post_pc", 8'h01);

        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
